// File: rtl/spi_sram_responder.sv
// Responder model of a 23LC1024-style serial SRAM (single-bit SPI mode 0).
// Bus inputs are oversampled in the clk domain; storage is an internal byte array.
module spi_sram_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned PAGE_SIZE  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       CSn,
  input  logic       SCK,
  input  logic       SI,
  output logic       SO,
  output logic       SO_oe,
  output logic [1:0] mode,
  output logic       wr_pulse
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam logic [AW-1:0] PageMask = AW'(PAGE_SIZE - 1);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StDataRd, StDataWr, StModeRd, StModeWr, StIgnore
  } state_e;

  logic          csn_s1_q, csn_s2_q, csn_prev_q;
  logic          sck_s1_q, sck_s2_q, sck_prev_q;
  logic          si_s1_q, si_s2_q;
  logic          sck_rise, sck_fall;

  state_e        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [6:0]    sh_q, sh_d;
  logic [7:0]    dout_q, dout_d;
  logic [AW-1:0] addr_q, addr_d, addr_inc, addr_next;
  logic          is_rd_q, is_rd_d;
  logic          fetch_q, fetch_d;
  logic          so_q, so_d;
  logic          oe_q, oe_d;
  logic [1:0]    mode_q, mode_d;
  logic          wr_pulse_q;
  logic          mem_we;
  logic [7:0]    rx_byte;
  logic [7:0]    mem_q [2**AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {csn_s1_q, csn_s2_q, csn_prev_q} <= 3'b111;
      {sck_s1_q, sck_s2_q, sck_prev_q} <= 3'b000;
      {si_s1_q, si_s2_q}               <= 2'b00;
    end else begin
      csn_s1_q   <= CSn;
      csn_s2_q   <= csn_s1_q;
      csn_prev_q <= csn_s2_q;
      sck_s1_q   <= SCK;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
      si_s1_q    <= SI;
      si_s2_q    <= si_s1_q;
    end
  end

  assign sck_rise = sck_s2_q & ~sck_prev_q;
  assign sck_fall = ~sck_s2_q & sck_prev_q;
  assign rx_byte  = {sh_q, si_s2_q};
  assign addr_inc = addr_q + 1'b1;

  // Page mode keeps the upper address bits and wraps the in-page offset.
  always_comb begin
    addr_next = addr_inc;
    if (mode_q == 2'b10) addr_next = (addr_q & ~PageMask) | (addr_inc & PageMask);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    addr_d  = addr_q;
    is_rd_d = is_rd_q;
    fetch_d = 1'b0;
    so_d    = so_q;
    oe_d    = oe_q;
    mode_d  = mode_q;
    mem_we  = 1'b0;

    if (csn_s2_q) begin
      if (state_q != StIdle) begin
        state_d = StIdle;
        oe_d    = 1'b0;
        so_d    = 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          // A rise coincident with the CSn fall is deliberately dropped here.
          if (csn_prev_q) begin
            state_d = StCmd;
            cnt_d   = '0;
          end
        end
        StCmd: begin
          if (sck_rise) begin
            sh_d  = rx_byte[6:0];
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d = '0;
              case (rx_byte)
                8'h03:   begin state_d = StAddr; is_rd_d = 1'b1; end
                8'h02:   begin state_d = StAddr; is_rd_d = 1'b0; end
                8'h05:   begin state_d = StModeRd; dout_d = {mode_q, 6'b0}; end
                8'h01:   state_d = StModeWr;
                default: state_d = StIgnore;
              endcase
            end
          end
        end
        StAddr: begin
          if (sck_rise) begin
            addr_d = {addr_q[AW-2:0], si_s2_q};
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
              cnt_d = '0;
              if (is_rd_q) begin
                state_d = StDataRd;
                fetch_d = 1'b1;
              end else begin
                state_d = StDataWr;
              end
            end
          end
        end
        StDataRd: begin
          if (fetch_q) begin
            dout_d = mem_q[addr_q];
          end else if (sck_fall) begin
            // cnt 8 marks a finished byte-mode read: release SO on this fall.
            if (cnt_q == 5'd8) begin
              oe_d    = 1'b0;
              state_d = StIgnore;
            end else begin
              so_d   = dout_q[7];
              oe_d   = 1'b1;
              dout_d = {dout_q[6:0], 1'b0};
              cnt_d  = cnt_q + 5'd1;
              if (cnt_q == 5'd7 && mode_q != 2'b00) begin
                cnt_d   = '0;
                addr_d  = addr_next;
                fetch_d = 1'b1;
              end
            end
          end
        end
        StDataWr: begin
          if (sck_rise) begin
            sh_d  = rx_byte[6:0];
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              mem_we = 1'b1;
              cnt_d  = '0;
              addr_d = addr_next;
              if (mode_q == 2'b00) state_d = StIgnore;
            end
          end
        end
        StModeRd: begin
          if (sck_fall) begin
            so_d   = dout_q[7];
            oe_d   = 1'b1;
            dout_d = {dout_q[6:0], dout_q[7]};
          end
        end
        StModeWr: begin
          if (sck_rise) begin
            sh_d  = rx_byte[6:0];
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              if (rx_byte[7:6] != 2'b11) mode_d = rx_byte[7:6];
              state_d = StIgnore;
            end
          end
        end
        StIgnore: oe_d = 1'b0;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sh_q       <= '0;
      dout_q     <= '0;
      addr_q     <= '0;
      is_rd_q    <= 1'b0;
      fetch_q    <= 1'b0;
      so_q       <= 1'b0;
      oe_q       <= 1'b0;
      mode_q     <= 2'b01;
      wr_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      dout_q     <= dout_d;
      addr_q     <= addr_d;
      is_rd_q    <= is_rd_d;
      fetch_q    <= fetch_d;
      so_q       <= so_d;
      oe_q       <= oe_d;
      mode_q     <= mode_d;
      wr_pulse_q <= mem_we;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q] <= rx_byte;
  end

  assign SO       = so_q;
  assign SO_oe    = oe_q;
  assign mode     = mode_q;
  assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Scoreboard bench for spi_sram_responder: SPI master tasks drive the bus and
// expected read bytes are queued before each read and compared on arrival.
module tb_spi_sram_responder;

  localparam int Half = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       CSn = 1'b1;
  logic       SCK = 1'b0;
  logic       SI = 1'b0;
  logic       SO, SO_oe, wr_pulse;
  logic [1:0] mode;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt = 0;
  logic [7:0] exp_q[$];

  spi_sram_responder #(.ADDR_WIDTH(10), .PAGE_SIZE(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .CSn      (CSn),
    .SCK      (SCK),
    .SI       (SI),
    .SO       (SO),
    .SO_oe    (SO_oe),
    .mode     (mode),
    .wr_pulse (wr_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_pulse) wr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic r);
    SI = b;
    tick(Half);
    r = SO;
    SCK = 1'b1;
    tick(Half);
    SCK = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic cs_lo();
    CSn = 1'b0;
    tick(4);
  endtask

  task automatic cs_hi();
    tick(Half);
    CSn = 1'b1;
    tick(3);
    check("oe_after_csn", SO_oe, 1'b0);
    tick(4);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] rx;
    spi_byte(cmd, rx);
    spi_byte(a[23:16], rx);
    spi_byte(a[15:8], rx);
    spi_byte(a[7:0], rx);
  endtask

  task automatic recv_cmp(input string tag);
    logic [7:0] rx;
    spi_byte(8'h00, rx);
    if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
    else check(tag, rx, exp_q.pop_front());
  endtask

  task automatic sram_write(input logic [23:0] a, input int n, input logic [7:0] d0,
                            input logic [7:0] d1);
    logic [7:0] rx;
    cs_lo();
    send_hdr(8'h02, a);
    spi_byte(d0, rx);
    if (n > 1) spi_byte(d1, rx);
    cs_hi();
  endtask

  task automatic sram_read(input logic [23:0] a, input int n);
    cs_lo();
    send_hdr(8'h03, a);
    for (int i = 0; i < n; i++) recv_cmp("rd_data");
    cs_hi();
  endtask

  task automatic mode_wr(input logic [7:0] v);
    logic [7:0] rx;
    cs_lo();
    spi_byte(8'h01, rx);
    spi_byte(v, rx);
    cs_hi();
  endtask

  initial begin
    int w0;
    int bad;
    logic r;
    logic [7:0] rx;

    tick(3);
    check("rst_oe", SO_oe, 1'b0);
    check("rst_so", SO, 1'b0);
    check("rst_mode", mode, 2'b01);
    check("rst_wr_pulse", wr_pulse, 1'b0);
    rst_n = 1'b1;
    tick(4);

    // Sequential write then read back.
    w0 = wr_cnt;
    sram_write(24'h000010, 2, 8'hA5, 8'h3C);
    check("wr_pulse_cnt2", wr_cnt - w0, 2);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    sram_read(24'h000010, 2);

    // Sequential wrap at the top of the array.
    sram_write(24'h0003FF, 1, 8'h11, 8'h00);
    sram_write(24'h000000, 1, 8'h22, 8'h00);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    sram_read(24'h0003FF, 2);

    // Aborted write leaves the prior value intact.
    sram_write(24'h000020, 1, 8'h5A, 8'h00);
    w0 = wr_cnt;
    cs_lo();
    send_hdr(8'h02, 24'h000020);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, r);
    cs_hi();
    check("abort_no_wr", wr_cnt - w0, 0);
    exp_q.push_back(8'h5A);
    sram_read(24'h000020, 1);

    // Page mode: write across the page boundary wraps within the page.
    mode_wr(8'h80);
    check("mode_page", mode, 2'b10);
    cs_lo();
    spi_byte(8'h05, rx);
    exp_q.push_back(8'h80);
    recv_cmp("rdmr");
    cs_hi();
    sram_write(24'h00001F, 2, 8'h01, 8'h02);
    exp_q.push_back(8'h02);
    sram_read(24'h000000, 1);
    exp_q.push_back(8'h5A);
    sram_read(24'h000020, 1);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    sram_read(24'h00001F, 2);

    // Byte mode: one byte out, then SO released.
    mode_wr(8'h00);
    check("mode_byte", mode, 2'b00);
    cs_lo();
    send_hdr(8'h03, 24'h000010);
    exp_q.push_back(8'hA5);
    recv_cmp("byte_rd");
    check("byte_oe_hold", SO_oe, 1'b1);
    tick(Half);
    SCK = 1'b1;
    tick(Half);
    SCK = 1'b0;
    tick(4);
    check("byte_oe_drop", SO_oe, 1'b0);
    cs_hi();

    mode_wr(8'hC0);
    check("mode_reserved", mode, 2'b00);
    mode_wr(8'h40);
    check("mode_seq", mode, 2'b01);

    // Unknown command never drives SO.
    bad = 0;
    cs_lo();
    spi_byte(8'h9F, rx);
    for (int i = 0; i < 32; i++) begin
      SI = 1'b0;
      tick(Half);
      if (SO_oe) bad++;
      SCK = 1'b1;
      tick(Half);
      if (SO_oe) bad++;
      SCK = 1'b0;
    end
    check("bad_cmd_oe", bad, 0);
    cs_hi();

    // Reset mid-read.
    mode_wr(8'h80);
    cs_lo();
    send_hdr(8'h03, 24'h000010);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
    check("midrd_oe_before", SO_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrd_rst_oe", SO_oe, 1'b0);
    check("midrd_rst_mode", mode, 2'b01);
    tick(2);
    CSn = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    sram_read(24'h000010, 2);

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
